// File: rtl/uart_echo_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_echo_fifo
// Purpose  : Buffered echo engine between the UART decoder and encoder.
//            Received characters are optionally transformed, queued in a
//            FIFO and replayed to the encoder with a start/busy handshake.
//            In CR->CRLF mode, a carriage return is followed by a line feed.
// Revision : 1.0 - initial release
// ============================================================================
module uart_echo_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int ARM_CYCLES = 2
) (
    input  logic                            i_Clk,
    input  logic                            i_Rst,
    input  logic                            i_RX_Valid,
    input  logic [DATA_WIDTH-1:0]           i_RX_Byte,
    output logic                            o_RX_Release,
    input  logic [1:0]                      i_Mode,
    output logic [DATA_WIDTH-1:0]           o_TX_Byte,
    output logic                            o_TX_Start,
    input  logic                            i_TX_Busy,
    output logic [DATA_WIDTH-1:0]           o_Last_Byte,
    output logic [$clog2(FIFO_DEPTH):0]     o_Count,
    output logic                            o_Full,
    output logic                            o_Empty,
    output logic                            o_Overflow,
    input  logic                            i_Clear_Overflow
);

    localparam int c_AW     = $clog2(FIFO_DEPTH);
    localparam int c_CW     = c_AW + 1;
    localparam int c_ARM_W  = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
    localparam logic [c_ARM_W-1:0] c_ARM_LAST = c_ARM_W'(ARM_CYCLES - 1);
    localparam logic [c_CW-1:0]    c_DEPTH    = c_CW'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_ARM       = 2'd1;
    localparam logic [1:0] S_WAIT_DONE = 2'd2;
    localparam logic [1:0] S_LF_ARM    = 2'd3;

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]       r_wr_ptr;
    logic [c_AW-1:0]       r_rd_ptr;
    logic [c_CW-1:0]       r_count;
    logic [1:0]            r_state;
    logic [c_ARM_W-1:0]    r_arm_cnt;
    logic                  r_lf_pending;
    logic [DATA_WIDTH-1:0] r_tx_byte;
    logic                  r_tx_start;
    logic [DATA_WIDTH-1:0] r_last_byte;
    logic                  r_release;
    logic                  r_overflow;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic [DATA_WIDTH-1:0] w_xform;
    logic [DATA_WIDTH-1:0] w_head;

    assign w_full  = (r_count == c_DEPTH);
    assign w_empty = (r_count == '0);
    assign w_head  = r_mem[r_rd_ptr];
    // A pop frees a slot in the same cycle, so a full FIFO still accepts a write then.
    assign w_pop   = (r_state == S_IDLE) && !w_empty && !i_TX_Busy && (i_Mode != 2'd3);
    assign w_push  = i_RX_Valid && (!w_full || w_pop);
    assign w_drop  = i_RX_Valid && w_full && !w_pop;

    // Uppercase transform acts on the low byte only; mode is sampled at write time.
    always_comb begin
        w_xform = i_RX_Byte;
        if ((i_Mode == 2'd1) && (i_RX_Byte[7:0] >= 8'h61) && (i_RX_Byte[7:0] <= 8'h7A)) begin
            w_xform[7:0] = i_RX_Byte[7:0] - 8'h20;
        end
    end

    // FIFO storage; content is flushed by resetting pointers, not the array.
    always_ff @(posedge i_Clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_xform;
        end
    end

    // Pointers, occupancy, release pulse, last byte and sticky overflow.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_last_byte <= '0;
            r_release   <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_release <= i_RX_Valid;
            if (w_push) begin
                r_wr_ptr    <= r_wr_ptr + 1'b1;
                r_last_byte <= w_xform;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (i_Clear_Overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Transmit FSM: pop, ignore busy while the encoder arms, wait, optional LF.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_state      <= S_IDLE;
            r_arm_cnt    <= '0;
            r_lf_pending <= 1'b0;
            r_tx_byte    <= '0;
            r_tx_start   <= 1'b0;
        end else begin
            r_tx_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_tx_byte    <= w_head;
                        r_tx_start   <= 1'b1;
                        r_lf_pending <= (w_head[7:0] == 8'h0D) && (i_Mode == 2'd2);
                        r_arm_cnt    <= '0;
                        r_state      <= S_ARM;
                    end
                end
                S_ARM, S_LF_ARM: begin
                    if (r_arm_cnt == c_ARM_LAST) begin
                        r_arm_cnt <= '0;
                        r_state   <= S_WAIT_DONE;
                    end else begin
                        r_arm_cnt <= r_arm_cnt + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!i_TX_Busy) begin
                        if (r_lf_pending) begin
                            r_tx_byte    <= DATA_WIDTH'(8'h0A);
                            r_tx_start   <= 1'b1;
                            r_lf_pending <= 1'b0;
                            r_arm_cnt    <= '0;
                            r_state      <= S_LF_ARM;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_RX_Release = r_release;
    assign o_TX_Byte    = r_tx_byte;
    assign o_TX_Start   = r_tx_start;
    assign o_Last_Byte  = r_last_byte;
    assign o_Count      = r_count;
    assign o_Full       = w_full;
    assign o_Empty      = w_empty;
    assign o_Overflow   = r_overflow;

endmodule
`default_nettype wire
